// File: rtl/mul_seq_pkg.sv
// ---------------------------------------------------------------------------
// mul_seq_pkg
// Shared definitions for the sequenced 8x8 multiplier controller.
//   state_t    : controller states (IDLE, MUL, DONE)
//   NIB_W      : width of one operand nibble fed to the 4x4 array
//   OP_W       : full operand width
//   STEPS      : number of partial-product steps per operation
//   stepShift  : left-shift applied to the partial product of each step
// ---------------------------------------------------------------------------
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;
  localparam int OP_W  = 8;
  localparam int STEPS = 4;

  // Shift table: step 0 is lo*lo, steps 1 and 2 are the cross terms,
  // step 3 is hi*hi.
  function automatic logic [3:0] stepShift(input logic [1:0] step);
    case (step)
      2'd0:    stepShift = 4'd0;
      2'd1:    stepShift = 4'd4;
      2'd2:    stepShift = 4'd4;
      default: stepShift = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mul8_seq_ctrl_multiplier_4x4.sv
// ---------------------------------------------------------------------------
// multiplier_4x4
// Purely combinational 4x4 unsigned array multiplier.
//   i_a : 4-bit multiplicand
//   i_b : 4-bit multiplier
//   o_p : 8-bit product
// ---------------------------------------------------------------------------
module multiplier_4x4
  import mul_seq_pkg::*;
(
  input  logic [NIB_W-1:0]   i_a,
  input  logic [NIB_W-1:0]   i_b,
  output logic [2*NIB_W-1:0] o_p
);

  logic [2*NIB_W-1:0] w_sum;

  // Each row of the array is the multiplicand gated by one multiplier bit,
  // weighted by that bit's position; the rows are summed into the product.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NIB_W; i++) begin
      w_sum = w_sum + ({{NIB_W{1'b0}}, (i_a & {NIB_W{i_b[i]}})} << i);
    end
  end

  assign o_p = w_sum;

endmodule

// File: rtl/mul8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul8_seq_ctrl
// Forms an 8x8 unsigned product (optionally accumulated) by running one
// shared 4x4 array multiplier over four consecutive clock cycles.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request, sampled only while not busy
//   mac   : sampled with start; 1 = add product to p, 0 = overwrite p
//   a, b  : 8-bit unsigned operands, captured when start is accepted
//   busy  : high while the four multiply steps are in flight
//   done  : one-cycle pulse, p valid in that cycle
//   p     : result / accumulator, held between operations
// ---------------------------------------------------------------------------
module mul8_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mac,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] p
);

  state_t             r_state;
  state_t             w_next;
  logic [1:0]         r_step;
  logic [OP_W-1:0]    r_a;
  logic [OP_W-1:0]    r_b;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_p;

  logic               w_accept;
  logic               w_lastStep;
  logic [NIB_W-1:0]   w_nibA;
  logic [NIB_W-1:0]   w_nibB;
  logic [2*NIB_W-1:0] w_pp;
  logic [ACC_W-1:0]   w_term;
  logic [ACC_W-1:0]   w_sum;

  // Nibble selection: step bit 0 picks the high half of a, step bit 1 picks
  // the high half of b, which walks lo*lo, hi*lo, lo*hi, hi*hi.
  assign w_nibA = r_step[0] ? r_a[OP_W-1:NIB_W] : r_a[NIB_W-1:0];
  assign w_nibB = r_step[1] ? r_b[OP_W-1:NIB_W] : r_b[NIB_W-1:0];

  multiplier_4x4 u_mult (
    .i_a (w_nibA),
    .i_b (w_nibB),
    .o_p (w_pp)
  );

  // Zero-extend the partial product, weight it for this step and add it to
  // the running sum; the adder width truncates so accumulation wraps.
  assign w_term = {{(ACC_W - 2*NIB_W){1'b0}}, w_pp} << stepShift(r_step);
  assign w_sum  = r_acc + w_term;

  assign w_lastStep = (r_step == 2'(STEPS - 1));

  // A request is only looked at when no multiply is in flight, which makes
  // DONE accept start exactly like IDLE for back-to-back operation.
  assign w_accept = start && (r_state != MUL);

  // Next-state logic and the status outputs decoded from the state.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (w_lastStep) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = start ? MUL : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register plus datapath registers. On accept the accumulator is
  // seeded from p (mac) or cleared; p itself only changes on the edge that
  // enters DONE so the master sees a stable value at all other times.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_p     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_step <= '0;
        r_acc  <= mac ? r_p : '0;
      end else if (r_state == MUL) begin
        r_acc  <= w_sum;
        r_step <= r_step + 2'd1;
        if (w_lastStep) r_p <= w_sum;
      end
    end
  end

  assign p = r_p;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul8_seq_ctrl
// Directed bench for mul8_seq_ctrl with hand-computed expected results,
// followed by a seeded sweep against a simple arithmetic model.
// ---------------------------------------------------------------------------
module tb_mul8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mac;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  int testsRun  = 0;
  int testsFail = 0;

  mul8_seq_ctrl #(.ACC_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mac   (mac),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request for a single cycle, then wait (bounded) for done.
  // Returns on the falling edge of the done cycle with the latency in
  // negedges counted from the drive edge.
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                               input logic opMac, output int lat);
    @(negedge clk);
    a = opA; b = opB; mac = opMac; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) checkOutput("opTimeout", 32'(lat), 32'd5);
  endtask

  int          lat;
  int          doneCount;
  logic [15:0] model;
  logic [7:0]  ra, rb;
  logic        rm;

  initial begin
    rst = 1'b1; start = 1'b0; mac = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstP",    32'(p),    32'd0);
    rst = 1'b0;

    // 1: max product, check busy profile and 5-cycle latency
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; mac = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1Busy%0d", i), 32'(busy), 32'd1);
      checkOutput($sformatf("t1NoDone%0d", i), 32'(done), 32'd0);
      checkOutput($sformatf("t1Hold%0d", i), 32'(p), 32'd0);
      @(negedge clk);
    end
    checkOutput("t1Done", 32'(done), 32'd1);
    checkOutput("t1BusyInDone", 32'(busy), 32'd0);
    checkOutput("t1P", 32'(p), 32'hFE01);
    @(negedge clk);
    checkOutput("t1DonePulse", 32'(done), 32'd0);
    checkOutput("t1PHeld", 32'(p), 32'hFE01);

    // 2: overwrite then accumulate
    applyStimulus(8'd13, 8'd11, 1'b0, lat);
    checkOutput("t2Lat", 32'(lat), 32'd5);
    checkOutput("t2P1", 32'(p), 32'd143);
    applyStimulus(8'd2, 8'd3, 1'b1, lat);
    checkOutput("t2P2", 32'(p), 32'd149);

    // 3: back-to-back with start held through DONE
    @(negedge clk);
    a = 8'h10; b = 8'h10; mac = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h0F; b = 8'h01;
    repeat (4) @(negedge clk);
    checkOutput("t3Done1", 32'(done), 32'd1);
    checkOutput("t3P1", 32'(p), 32'h0100);
    @(negedge clk);
    start = 1'b0;
    checkOutput("t3Busy2", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t3Gap%0d", i), 32'(done), 32'd0);
    end
    @(negedge clk);
    checkOutput("t3Done2", 32'(done), 32'd1);
    checkOutput("t3P2", 32'(p), 32'h000F);

    // 4: start re-asserted during step 1 is ignored
    @(negedge clk);
    a = 8'd3; b = 8'd5; mac = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'd9; b = 8'd9; mac = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        doneCount++;
        checkOutput("t4P", 32'(p), 32'd15);
      end
      @(negedge clk);
    end
    checkOutput("t4DoneCount", 32'(doneCount), 32'd1);

    // 5: reset during step 2
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; mac = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t5Busy", 32'(busy), 32'd0);
    checkOutput("t5Done", 32'(done), 32'd0);
    checkOutput("t5P", 32'(p), 32'd0);
    applyStimulus(8'd7, 8'd6, 1'b0, lat);
    checkOutput("t5Lat", 32'(lat), 32'd5);
    checkOutput("t5PNew", 32'(p), 32'd42);

    // 6: accumulate wrap at 16 bits
    applyStimulus(8'd0, 8'd0, 1'b0, lat);
    checkOutput("t6Clear", 32'(p), 32'd0);
    for (int i = 0; i < 257; i++) applyStimulus(8'hFF, 8'h01, 1'b1, lat);
    checkOutput("t6Preload", 32'(p), 32'hFFFF);
    applyStimulus(8'd1, 8'd1, 1'b1, lat);
    checkOutput("t6Wrap", 32'(p), 32'h0000);

    // Sweep: seeded operands and mode against a modular arithmetic model
    model = p;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rm = 1'($urandom_range(0, 1));
      if (rm) model = model + 16'(ra) * 16'(rb);
      else    model = 16'(ra) * 16'(rb);
      applyStimulus(ra, rb, rm, lat);
      checkOutput($sformatf("sweep%0d", i), 32'(p), 32'(model));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
